// File: rtl/matmul_chip_interface.sv
// rtl/matmul_chip_interface.sv - board top: ROM-based N x N matrix multiply with 7-segment result display
module matmul_chip_interface #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic       CLOCK_50,
   input  logic [0:0] KEY,
   input  logic [0:0] SW,
   output logic [6:0] HEX5,
   output logic [6:0] HEX4,
   output logic [6:0] HEX3,
   output logic [6:0] HEX2,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = 2 * W + $clog2(N);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [IW-1:0]   r_i;
   logic [IW-1:0]   r_j;
   logic [IW-1:0]   r_k;
   logic [CW-1:0]   r_acc;
   logic [CW-1:0]   r_c [N][N];
   logic [23:0]     r_checksum;
   logic [23:0]     r_cycle_count;
   logic            done_computing;

   logic            w_resetn;
   logic            w_last_k;
   logic            w_last_j;
   logic            w_last;
   logic [W-1:0]    w_a;
   logic [W-1:0]    w_b;
   logic [CW-1:0]   w_acc_next;
   logic [23:0]     w_value;

   assign w_resetn = KEY[0];
   assign w_last_k = (r_k == IW'(N - 1));
   assign w_last_j = (r_j == IW'(N - 1));
   assign w_last   = w_last_k && w_last_j && (r_i == IW'(N - 1));

   // ROM contents are pure functions of the indices, so no storage is needed
   assign w_a        = W'(int'(r_i) * N + int'(r_k) + 1);
   assign w_b        = W'(int'(r_k) + 1);
   assign w_acc_next = r_acc + CW'(w_a) * CW'(w_b);

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (!w_resetn) r_state <= IDLE;
      else           r_state <= w_next_state;
   end

   // Next-state logic: start immediately out of reset, stop after the last MAC
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = COMPUTE;
         COMPUTE: if (w_last) w_next_state = DONE;
         DONE:    w_next_state = DONE;
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath: one MAC per cycle, k innermost, then j, then i
   always_ff @(posedge CLOCK_50) begin
      if (!w_resetn) begin
         r_i            <= '0;
         r_j            <= '0;
         r_k            <= '0;
         r_acc          <= '0;
         r_checksum     <= '0;
         r_cycle_count  <= '0;
         done_computing <= 1'b0;
         for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
               r_c[a][b] <= '0;
      end else begin
         case (r_state)
            COMPUTE: begin
               r_cycle_count <= r_cycle_count + 24'd1;
               if (w_last_k) begin
                  r_c[r_i][r_j] <= w_acc_next;
                  r_checksum    <= r_checksum + 24'(w_acc_next);
                  r_acc         <= '0;
                  r_k           <= '0;
                  if (w_last_j) begin
                     r_j <= '0;
                     r_i <= r_i + IW'(1);
                  end else begin
                     r_j <= r_j + IW'(1);
                  end
               end else begin
                  r_acc <= w_acc_next;
                  r_k   <= r_k + IW'(1);
               end
            end
            DONE:    done_computing <= 1'b1;
            default: ;
         endcase
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   // Display select is combinational so SW can change at any time
   assign w_value = SW[0] ? r_cycle_count : r_checksum;

   assign HEX5 = done_computing ? seg7(w_value[23:20]) : 7'h7F;
   assign HEX4 = done_computing ? seg7(w_value[19:16]) : 7'h7F;
   assign HEX3 = done_computing ? seg7(w_value[15:12]) : 7'h7F;
   assign HEX2 = done_computing ? seg7(w_value[11:8])  : 7'h7F;
   assign HEX1 = done_computing ? seg7(w_value[7:4])   : 7'h7F;
   assign HEX0 = done_computing ? seg7(w_value[3:0])   : 7'h7F;

endmodule

// File: tb/tb_matmul_chip_interface.sv
// tb/tb_matmul_chip_interface.sv - self-checking bench for matmul_chip_interface
module tb_matmul_chip_interface;

   localparam int N = 4;
   localparam int W = 8;
   localparam logic [41:0] BLANK = {6{7'h7F}};

   logic       clk;
   logic [0:0] key;
   logic [0:0] sw;
   logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

   int checks;
   int errors;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      logic        sw;
      logic [41:0] hex;
   } vec_t;

   vec_t vecs [5];

   longint      c_ref [N][N];
   logic [23:0] checksum_ref;
   int          cycles_ref;
   int          latency_ref;

   matmul_chip_interface #(.N(N), .W(W)) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .SW       (sw),
      .HEX5     (hex5),
      .HEX4     (hex4),
      .HEX3     (hex3),
      .HEX2     (hex2),
      .HEX1     (hex1),
      .HEX0     (hex0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [41:0] all_hex();
      return {hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   function automatic logic [41:0] hex_ref(input logic [23:0] v);
      logic [41:0] r;
      for (int d = 0; d < 6; d++)
         r[d*7 +: 7] = seg_tab[v[d*4 +: 4]];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: straight matrix product from the ROM definitions
   task automatic build_model();
      checksum_ref = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            c_ref[i][j] = 0;
            for (int k = 0; k < N; k++)
               c_ref[i][j] += longint'(i * N + k + 1) * longint'(k + 1);
            checksum_ref = checksum_ref + 24'(c_ref[i][j]);
         end
      cycles_ref  = N * N * N;
      latency_ref = N * N * N + 2;
   endtask

   task automatic reset_for(input int cycles);
      @(negedge clk);
      key = 1'b0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      key = 1'b1;
   endtask

   // Counts edges after release until done; SW is scrambled meanwhile
   task automatic run_to_done(output int edges, output logic blank_ok);
      edges    = 1000;
      blank_ok = 1'b1;
      for (int n = 1; n <= 1000; n++) begin
         @(posedge clk);
         #1;
         if (dut.done_computing === 1'b1) begin
            edges = n;
            break;
         end
         if (all_hex() !== BLANK) blank_ok = 1'b0;
         @(negedge clk);
         sw = 1'($urandom);
      end
      @(negedge clk);
      sw = 1'b0;
      #1;
   endtask

   task automatic check_results(input string tag);
      check({tag, "_checksum"}, 64'(dut.r_checksum), 64'(checksum_ref));
      check({tag, "_cycles"}, 64'(dut.r_cycle_count), 64'(cycles_ref));
      check({tag, "_hex_sw0"}, 64'(all_hex()), 64'(hex_ref(checksum_ref)));
   endtask

   initial begin
      int          edges;
      int          abort_at;
      logic        ok;

      checks = 0;
      errors = 0;
      key    = 1'b0;
      sw     = 1'b0;
      build_model();

      vecs[0] = '{sw: 1'b0, hex: {7'h40, 7'h40, 7'h40, 7'h12, 7'h08, 7'h40}};
      vecs[1] = '{sw: 1'b1, hex: {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40}};
      vecs[2] = '{sw: 1'b0, hex: {7'h40, 7'h40, 7'h40, 7'h12, 7'h08, 7'h40}};
      vecs[3] = '{sw: 1'b1, hex: {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40}};
      vecs[4] = '{sw: 1'b0, hex: {7'h40, 7'h40, 7'h40, 7'h12, 7'h08, 7'h40}};

      // Long reset hold: nothing may start or show
      @(negedge clk);
      ok = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         if (dut.done_computing !== 1'b0 || all_hex() !== BLANK) ok = 1'b0;
         @(negedge clk);
         sw = 1'($urandom);
      end
      check("reset_hold_idle", 64'(ok), 64'(1));
      check("reset_done", 64'(dut.done_computing), 64'(0));
      check("reset_cycles", 64'(dut.r_cycle_count), 64'(0));
      check("reset_checksum", 64'(dut.r_checksum), 64'(0));
      sw  = 1'b0;
      key = 1'b1;

      // First full run
      run_to_done(edges, ok);
      check("latency", 64'(edges), 64'(latency_ref));
      check("blank_before_done", 64'(ok), 64'(1));
      check_results("run1");
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            check($sformatf("c_%0d_%0d", i, j), 64'(dut.r_c[i][j]), 64'(c_ref[i][j]));

      // Display select table, including toggling back
      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         sw = vecs[v].sw;
         #1;
         check($sformatf("disp_vec%0d", v), 64'(all_hex()), 64'(vecs[v].hex));
         check($sformatf("disp_model%0d", v), 64'(all_hex()),
               64'(hex_ref(vecs[v].sw ? 24'(cycles_ref) : checksum_ref)));
      end
      sw = 1'b0;

      // Reset after done must clear done on that same edge
      @(negedge clk);
      key = 1'b0;
      @(posedge clk);
      #1;
      check("done_drop_from_done", 64'(dut.done_computing), 64'(0));
      check("blank_after_reset", 64'(all_hex()), 64'(BLANK));
      @(negedge clk);
      key = 1'b1;

      // Aborted runs: fixed 30 cycles into COMPUTE, then random points
      for (int t = 0; t < 4; t++) begin
         abort_at = (t == 0) ? 30 : int'($urandom_range(1, N * N * N - 1));
         ok = 1'b1;
         for (int n = 0; n < abort_at + 1; n++) begin
            @(posedge clk);
            #1;
            if (dut.done_computing !== 1'b0 || all_hex() !== BLANK) ok = 1'b0;
         end
         check($sformatf("abort%0d_compute_blank", t), 64'(ok), 64'(1));
         @(negedge clk);
         key = 1'b0;
         @(posedge clk);
         #1;
         check($sformatf("abort%0d_done_low", t), 64'(dut.done_computing), 64'(0));
         check($sformatf("abort%0d_cnt_clear", t), 64'(dut.r_cycle_count), 64'(0));
         @(negedge clk);
         key = 1'b1;
         run_to_done(edges, ok);
         check($sformatf("abort%0d_latency", t), 64'(edges), 64'(latency_ref));
         check_results($sformatf("abort%0d", t));
         @(negedge clk);
         key = 1'b0;
         @(negedge clk);
         key = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
